sc_reg_backg_bank: RTL
======================

// Module: sc_reg_backg_bank
// PURPOSE
//  Multi-row background-pattern register bank: ROWS registers of DATAWIDTH bits each.
//  Each row can be written individually. All rows rotate together, either manually or on a programmable tick.
//  A whole frame can be loaded through a valid/ready handshake; the bank writes it one row per clock.
//  Sits between the game FSM (load, shift and transition requests) and the matrix display driver (data_OutBUS).
// PARAMETERS
//  RegBACKGBANK_DATAWIDTH   8   bits per row
//  RegBACKGBANK_ROWS        4   number of rows, >=2
//  RegBACKGBANK_ADDRWIDTH   2   row address width, =clog2(ROWS)
//  RegBACKGBANK_TICKWIDTH   8   auto-shift period counter width
//  DATA_FIXED_INITREGBACKG  0   value written to every row by synchronous clear
// PORTS
//  SC_RegBACKGBANK_CLOCK_50               in   1     system clock, rising edge
//  SC_RegBACKGBANK_RESET_InLow            in   1     asynchronous reset, active low
//  SC_RegBACKGBANK_clear_InLow            in   1     synchronous clear of all rows, active low
//  SC_RegBACKGBANK_load_InLow             in   1     write data_InBUS into the row at addr_InBUS, active low
//  SC_RegBACKGBANK_addr_InBUS             in   AW    row address for load and for rowdata_OutBUS
//  SC_RegBACKGBANK_data_InBUS             in   DW    row write data
//  SC_RegBACKGBANK_shiftselection_In      in   2     00 hold, 01 rotate left, 10 rotate right, 11 hold
//  SC_RegBACKGBANK_autoshift_In           in   1     0: rotate every cycle; 1: rotate only on tick
//  SC_RegBACKGBANK_period_InBUS           in   TW    tick period in clocks; 0 is treated as 1
//  SC_RegBACKGBANK_transvalid_In          in   1     frame load request
//  SC_RegBACKGBANK_transready_Out         out  1     bank can accept a frame
//  SC_RegBACKGBANK_transDATA_InBUS        in   R*DW  frame; row r = bits [r*DW +: DW]
//  SC_RegBACKGBANK_transdone_Out          out  1     one-cycle pulse when the frame is fully written
//  SC_RegBACKGBANK_tick_Out               out  1     one-cycle pulse on each auto-shift event
//  SC_RegBACKGBANK_data_OutBUS            out  R*DW  all rows, flattened like transDATA
//  SC_RegBACKGBANK_rowdata_OutBUS         out  DW    row[addr_InBUS], combinational read
// BEHAVIOUR
//  Reset (RESET_InLow=0, async):
//   - all rows 0; state IDLE; tick count 0; transready=1; transdone=0; tick=0.
//  FSM states: IDLE, LOAD, DONE.
//   - IDLE->LOAD when transvalid&&transready: frame captured into a buffer, row index=0.
//   - LOAD: writes buffer row[idx] to row[idx] each cycle; after ROWS-1 goes to DONE.
//   - DONE: transdone=1 for exactly 1 cycle, then IDLE.
//   - transready=1 only in IDLE.
//   - Accept at edge k: row r updated at edge k+1+r; transdone high in the cycle after edge k+ROWS.
//  IDLE priority per edge, highest first:
//   1. clear: all rows <= INIT; count <= 0.
//   2. transfer accept: rows unchanged this edge.
//   3. load: only row[addr] <= data_InBUS; no shift this edge; count holds.
//   4. shift event: all rows rotate by 1 bit.
//      - Left: {row[DW-2:0],row[DW-1]}.
//      - Right: {row[0],row[DW-1:1]}.
//  Shift event:
//   - autoshift=0: every cycle with shiftselection 01/10.
//   - autoshift=1: only on tick.
//  Tick counter (active only when autoshift=1 and shiftselection is 01/10):
//   - Increments each cycle.
//   - When count >= max(period,1)-1: tick=1 (combinational, same cycle) and count <= 0.
//   - A period reduced below the current count wraps on the next cycle.
//   - Otherwise count <= 0 and tick=0.
//  Counter in LOAD/DONE: held at 0; shift and load requests are ignored, tick=0.
//  clear in LOAD or DONE:
//   - aborts the transfer; all rows <= INIT; state IDLE.
//   - transdone not pulsed; transready=1 next cycle.
//  Reset mid-transfer: immediate return to the reset values above.
//  load with addr >= ROWS: ignored. rowdata_OutBUS reads 0 for addr >= ROWS.
// TESTING (DW=8, ROWS=4)
//  - Reset low, then high -> data_OutBUS=32'h0, transready=1.
//    load addr=2 data=8'hA5 -> row2=A5, other rows 0.
//  - Rows = 81,01,80,FF; sel=01, autoshift=0, 1 clock -> 03,02,01,FF.
//    sel=10, 1 clock -> 81,01,80,FF.
//  - autoshift=1, period=3, sel=01, row0=01 -> tick every 3rd clock; row0 = 02,04,08 after 3,6,9 clocks.
//    period=0 -> tick every clock.
//  - transvalid with frame 32'h44332211 accepted at edge k -> row0=11 @k+1, ... row3=44 @k+4.
//    transdone pulse 1 cycle; transready low k+1..k+5; load during LOAD ignored.
//  - Same transfer, clear_InLow=0 at k+2 -> all rows INIT, no transdone, transready=1 next cycle.
//  - clear and load on the same edge -> clear wins.
//    load and shift event on the same edge -> load applied, no rotate.
//    RESET_InLow asserted mid-LOAD -> outputs 0 asynchronously.

Source files
------------

// File: rtl/sc_reg_backg_bank.sv
// Background-pattern register bank: ROWS rows of DATAWIDTH bits with per-row load,
// common rotation (manual or ticked) and a handshaked whole-frame transfer written one row per clock.
module sc_reg_backg_bank #(
    parameter int RegBACKGBANK_DATAWIDTH = 8,
    parameter int RegBACKGBANK_ROWS      = 4,
    parameter int RegBACKGBANK_ADDRWIDTH = 2,
    parameter int RegBACKGBANK_TICKWIDTH = 8,
    parameter logic [RegBACKGBANK_DATAWIDTH-1:0] DATA_FIXED_INITREGBACKG = '0
) (
    input  logic                                               SC_RegBACKGBANK_CLOCK_50,
    input  logic                                               SC_RegBACKGBANK_RESET_InLow,
    input  logic                                               SC_RegBACKGBANK_clear_InLow,
    input  logic                                               SC_RegBACKGBANK_load_InLow,
    input  logic [RegBACKGBANK_ADDRWIDTH-1:0]                  SC_RegBACKGBANK_addr_InBUS,
    input  logic [RegBACKGBANK_DATAWIDTH-1:0]                  SC_RegBACKGBANK_data_InBUS,
    input  logic [1:0]                                         SC_RegBACKGBANK_shiftselection_In,
    input  logic                                               SC_RegBACKGBANK_autoshift_In,
    input  logic [RegBACKGBANK_TICKWIDTH-1:0]                  SC_RegBACKGBANK_period_InBUS,
    input  logic                                               SC_RegBACKGBANK_transvalid_In,
    output logic                                               SC_RegBACKGBANK_transready_Out,
    input  logic [RegBACKGBANK_ROWS*RegBACKGBANK_DATAWIDTH-1:0] SC_RegBACKGBANK_transDATA_InBUS,
    output logic                                               SC_RegBACKGBANK_transdone_Out,
    output logic                                               SC_RegBACKGBANK_tick_Out,
    output logic [RegBACKGBANK_ROWS*RegBACKGBANK_DATAWIDTH-1:0] SC_RegBACKGBANK_data_OutBUS,
    output logic [RegBACKGBANK_DATAWIDTH-1:0]                  SC_RegBACKGBANK_rowdata_OutBUS
);
    localparam int DW = RegBACKGBANK_DATAWIDTH;
    localparam int ROWS = RegBACKGBANK_ROWS;
    localparam int AW = RegBACKGBANK_ADDRWIDTH;
    localparam int TW = RegBACKGBANK_TICKWIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t                     r_state, w_state_next;
    logic [ROWS-1:0][DW-1:0]    r_rows, w_rows_next;
    logic [ROWS-1:0][DW-1:0]    r_frame, w_frame_next;
    logic [ROWS-1:0][DW-1:0]    w_rows_rotl, w_rows_rotr;
    logic [AW-1:0]              r_idx, w_idx_next;
    logic [TW-1:0]              r_count, w_count_next;
    logic [TW-1:0]              w_period_m1;
    logic                       w_clear, w_addr_ok, w_load, w_rot_sel, w_shift, w_tick;

    assign w_clear     = ~SC_RegBACKGBANK_clear_InLow;
    assign w_addr_ok   = (32'(SC_RegBACKGBANK_addr_InBUS) < ROWS);
    assign w_load      = ~SC_RegBACKGBANK_load_InLow & w_addr_ok;
    assign w_rot_sel   = (SC_RegBACKGBANK_shiftselection_In == 2'b01) ||
                         (SC_RegBACKGBANK_shiftselection_In == 2'b10);
    // A period of 0 behaves like 1, so the wrap threshold never underflows.
    assign w_period_m1 = (SC_RegBACKGBANK_period_InBUS == '0) ? '0
                                                               : SC_RegBACKGBANK_period_InBUS - TW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_rot
            assign w_rows_rotl[gi] = {r_rows[gi][DW-2:0], r_rows[gi][DW-1]};
            assign w_rows_rotr[gi] = {r_rows[gi][0], r_rows[gi][DW-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_rows_next  = r_rows;
        w_frame_next = r_frame;
        w_idx_next   = r_idx;
        w_count_next = r_count;
        w_shift      = 1'b0;
        w_tick       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clear) begin
                    w_rows_next  = {ROWS{DATA_FIXED_INITREGBACKG}};
                    w_count_next = '0;
                end else if (SC_RegBACKGBANK_transvalid_In) begin
                    w_state_next = ST_LOAD;
                    w_frame_next = SC_RegBACKGBANK_transDATA_InBUS;
                    w_idx_next   = '0;
                    w_count_next = '0;
                end else if (w_load) begin
                    w_rows_next[SC_RegBACKGBANK_addr_InBUS] = SC_RegBACKGBANK_data_InBUS;
                end else if (w_rot_sel) begin
                    if (!SC_RegBACKGBANK_autoshift_In) begin
                        w_shift      = 1'b1;
                        w_count_next = '0;
                    end else if (r_count >= w_period_m1) begin
                        // ">=" lets a period shortened below the count wrap at once.
                        w_shift      = 1'b1;
                        w_tick       = 1'b1;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + TW'(1);
                    end
                end else begin
                    w_count_next = '0;
                end
                if (w_shift) begin
                    w_rows_next = (SC_RegBACKGBANK_shiftselection_In == 2'b01) ? w_rows_rotl
                                                                               : w_rows_rotr;
                end
            end
            ST_LOAD: begin
                w_count_next = '0;
                if (w_clear) begin
                    w_rows_next  = {ROWS{DATA_FIXED_INITREGBACKG}};
                    w_state_next = ST_IDLE;
                end else begin
                    w_rows_next[r_idx] = r_frame[r_idx];
                    if (r_idx == AW'(ROWS - 1)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_idx_next = r_idx + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                w_count_next = '0;
                w_state_next = ST_IDLE;
                if (w_clear) begin
                    w_rows_next = {ROWS{DATA_FIXED_INITREGBACKG}};
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_RegBACKGBANK_CLOCK_50 or negedge SC_RegBACKGBANK_RESET_InLow) begin
        if (!SC_RegBACKGBANK_RESET_InLow) begin
            r_state <= ST_IDLE;
            r_rows  <= '0;
            r_frame <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_rows  <= w_rows_next;
            r_frame <= w_frame_next;
            r_idx   <= w_idx_next;
            r_count <= w_count_next;
        end
    end

    assign SC_RegBACKGBANK_transready_Out = (r_state == ST_IDLE);
    // A clear during the completion cycle aborts the transfer, so no done pulse.
    assign SC_RegBACKGBANK_transdone_Out  = (r_state == ST_DONE) && !w_clear;
    assign SC_RegBACKGBANK_tick_Out       = w_tick;
    assign SC_RegBACKGBANK_data_OutBUS    = r_rows;
    assign SC_RegBACKGBANK_rowdata_OutBUS = w_addr_ok ? r_rows[SC_RegBACKGBANK_addr_InBUS] : '0;

endmodule
